// File: rtl/acc_drain_quantizer.sv
// -----------------------------------------------------------------------------
// acc_drain_quantizer
//
// Purpose:
//   Drains the accumulator memory, entries 0..DEPTH-1 in order, after a Start
//   request. Each unsigned partial sum is right-shifted by a latched amount,
//   saturated to OUT_WIDTH and presented on a valid/ready stream.
//   Done pulses once the last entry has been accepted.
//
// Optional feature (compile-time macro ACC_DRAIN_ROUND_EN):
//   When defined, round-half-up is applied before the shift. For Shift values
//   1..PARTIAL_SUM_WIDTH-1, 2^(Shift-1) is added at PARTIAL_SUM_WIDTH+1 bits,
//   so the add cannot wrap. Saturation is applied after rounding.
//   When not defined, only the truncating shift is built and there is no adder.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   Start        in   drain request, sampled only in IDLE
//   Shift        in   right-shift amount, latched when Start is accepted
//   Acc_Rd_en    out  accumulator read strobe (registered)
//   Acc_Rd_Addr  out  accumulator read address (registered)
//   Acc_Rd_Data  in   entry data, valid one cycle after Acc_Rd_en
//   Out_valid    out  Out_Data and Out_Addr are valid
//   Out_ready    in   consumer ready; a transfer occurs when valid && ready
//   Out_Data     out  quantized value
//   Out_Addr     out  source entry index of Out_Data
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle pulse after the last transfer
//   Sat_Flag     out  sticky saturation flag for the current drain
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for Start
// RD    | Acc_Rd_en high, Acc_Rd_Addr = cnt
// CAP   | read data is on Acc_Rd_Data; quantize it and load the output regs
// HOLD  | Out_valid high, waiting for Out_ready
// DONE  | Done pulse, then return to IDLE
// -----------------------------------------------------------------------------
module acc_drain_quantizer #(
  parameter int PARTIAL_SUM_WIDTH = 45,
  parameter int DEPTH             = 8,
  parameter int ADDR_WIDTH        = 3,
  parameter int OUT_WIDTH         = 8,
  parameter int SHIFT_WIDTH       = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Start,
  input  logic [SHIFT_WIDTH-1:0]       Shift,
  output logic                         Acc_Rd_en,
  output logic [ADDR_WIDTH-1:0]        Acc_Rd_Addr,
  input  logic [PARTIAL_SUM_WIDTH-1:0] Acc_Rd_Data,
  output logic                         Out_valid,
  input  logic                         Out_ready,
  output logic [OUT_WIDTH-1:0]         Out_Data,
  output logic [ADDR_WIDTH-1:0]        Out_Addr,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Sat_Flag
);

  // One extra bit so the rounding add never wraps. The truncating build
  // uses the same width so the saturation check is shared.
  localparam int SUM_W = PARTIAL_SUM_WIDTH + 1;
  localparam logic [31:0] PSW_U = PARTIAL_SUM_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]     out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
  logic                     done_q, done_d;
  logic                     sat_q, sat_d;

  // Quantizer datapath
  logic                     shift_ok;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         q_wide;
  logic                     q_ovf;
  logic [OUT_WIDTH-1:0]     q_sat;

`ifdef ACC_DRAIN_ROUND_EN
  logic [SUM_W-1:0]         round_add;
`endif

  always_comb begin
    // Shifts of PARTIAL_SUM_WIDTH or more flush every bit out; force zero
    // rather than relying on the shifter's behaviour for large amounts.
    shift_ok = (32'(shift_q) < PSW_U);
`ifdef ACC_DRAIN_ROUND_EN
    round_add = '0;
    if (shift_ok && (shift_q != '0)) begin
      round_add = SUM_W'(1) << (shift_q - SHIFT_WIDTH'(1));
    end
    sum = {1'b0, Acc_Rd_Data} + round_add;
`else
    sum = {1'b0, Acc_Rd_Data};
`endif
    q_wide = shift_ok ? (sum >> shift_q) : '0;
    q_ovf  = |q_wide[SUM_W-1:OUT_WIDTH];
    q_sat  = q_ovf ? '1 : q_wide[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  // The read strobe and Done are registered on the transition into RD and
  // DONE, so each is high for exactly the cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    sat_d       = sat_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          shift_d   = Shift;
          sat_d     = 1'b0;
          cnt_d     = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = S_RD;
        end
      end

      S_RD: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        out_data_d  = q_sat;
        out_addr_d  = cnt_q;
        out_valid_d = 1'b1;
        if (q_ovf) begin
          sat_d = 1'b1;
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (Out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
            rd_en_d   = 1'b1;
            rd_addr_d = cnt_q + ADDR_WIDTH'(1);
            state_d   = S_RD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Acc_Rd_en   = rd_en_q;
  assign Acc_Rd_Addr = rd_addr_q;
  assign Out_valid   = out_valid_q;
  assign Out_Data    = out_data_q;
  assign Out_Addr    = out_addr_q;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign Sat_Flag    = sat_q;

endmodule

// File: tb/tb_acc_drain_quantizer.sv
// Self-checking bench for acc_drain_quantizer. The accumulator memory is
// modelled here, and the expected output of every entry is computed with
// plain 64-bit arithmetic from the quantization rules.
module tb_acc_drain_quantizer;

  localparam int PSW   = 45;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int OW    = 8;
  localparam int SW    = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           Start = 1'b0;
  logic [SW-1:0]  Shift = '0;
  logic           Acc_Rd_en;
  logic [AW-1:0]  Acc_Rd_Addr;
  logic [PSW-1:0] Acc_Rd_Data = '0;
  logic           Out_valid;
  logic           Out_ready = 1'b0;
  logic [OW-1:0]  Out_Data;
  logic [AW-1:0]  Out_Addr;
  logic           Busy;
  logic           Done;
  logic           Sat_Flag;

  logic [PSW-1:0] mem [DEPTH];
  logic [18:0]    outs_all;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_drain_quantizer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Shift       (Shift),
    .Acc_Rd_en   (Acc_Rd_en),
    .Acc_Rd_Addr (Acc_Rd_Addr),
    .Acc_Rd_Data (Acc_Rd_Data),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Out_Data    (Out_Data),
    .Out_Addr    (Out_Addr),
    .Busy        (Busy),
    .Done        (Done),
    .Sat_Flag    (Sat_Flag)
  );

  assign outs_all = {Acc_Rd_en, Acc_Rd_Addr, Out_valid, Out_Data, Out_Addr, Busy, Done, Sat_Flag};

  // Accumulator memory: data appears one cycle after the strobe; otherwise
  // the bus carries junk so a mistimed capture is visible.
  always @(posedge clk) begin
    if (Acc_Rd_en) Acc_Rd_Data <= mem[Acc_Rd_Addr];
    else           Acc_Rd_Data <= PSW'({$urandom, $urandom});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {saturated, value}.
  function automatic logic [8:0] ref_q(input logic [PSW-1:0] d, input int s);
    longint unsigned v;
    v = 64'(d);
    if (s >= PSW) v = 0;
    else begin
`ifdef ACC_DRAIN_ROUND_EN
      if (s > 0) v = v + (64'd1 << (s - 1));
`endif
      v = v >> s;
    end
    if (v > 255) return 9'h1FF;
    return {1'b0, v[7:0]};
  endfunction

  function automatic logic [PSW-1:0] rand45();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r >> $urandom_range(19, 63);
    return r[PSW-1:0];
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < DEPTH; k++) mem[k] = rand45();
  endtask

  // mode 0: ready always high; 1: stall 5 cycles on entry 2; 2: random ready.
  // ign: pulse Start mid-drain with a different Shift. abort: reset in HOLD of entry 4.
  task automatic run_drain(input logic [SW-1:0] sh, input int mode, input bit ign, input bit abort);
    logic [8:0] exp_q [DEPTH];
    logic exp_sat;
    int n, xi, ri, stall;
    bit finished, aborted, prev_stall;
    exp_sat = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q[k] = ref_q(mem[k], int'(sh));
      exp_sat  = exp_sat | exp_q[k][8];
    end
    @(negedge clk);
    chk("idle_busy", Busy, 0);
    Start = 1'b1;
    Shift = sh;
    Out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0; xi = 0; ri = 0; stall = 0;
    finished = 0; aborted = 0; prev_stall = 0;
    while (!finished && n < 300) begin
      @(negedge clk);
      Start = (ign && n == 5);
      Shift = (ign && n == 5) ? ~sh : sh;
      if (n == 0) begin
        chk("busy_on", Busy, 1);
        chk("sat_clr", Sat_Flag, 0);
      end
      if (abort && Out_valid && Out_Addr == 3'd4) begin
        Out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_zero", outs_all, 0);
        aborted = 1;
        finished = 1;
      end else if (Done) begin
        chk("xfers", xi, DEPTH);
        chk("reads", ri, DEPTH);
        if (mode == 0) chk("done_cycle", n, 24);
        finished = 1;
      end else begin
        if (Acc_Rd_en) begin
          chk("rd_addr", Acc_Rd_Addr, ri);
          chk("rd_no_valid", Out_valid, 0);
          ri++;
        end
        if (prev_stall) chk("held_valid", Out_valid, 1);
        if (Out_valid) begin
          if (mode == 0 && xi == 0) chk("first_valid", n, 2);
          if (xi < DEPTH) begin
            chk("out_addr", Out_Addr, xi);
            chk("out_data", Out_Data, exp_q[xi][7:0]);
          end else begin
            chk("extra_xfer", 1, 0);
          end
        end
        case (mode)
          0: Out_ready = 1'b1;
          1: begin
            if (Out_valid && Out_Addr == 3'd2 && stall < 5) begin
              Out_ready = 1'b0;
              stall++;
            end else begin
              Out_ready = 1'b1;
            end
          end
          default: Out_ready = 1'($urandom_range(0, 1));
        endcase
        prev_stall = Out_valid && !Out_ready;
        if (Out_valid && Out_ready) xi++;
      end
      n++;
    end
    if (!finished) chk("done_timeout", 0, 1);
    if (!aborted) begin
      @(negedge clk);
      chk("done_pulse", Done, 0);
      chk("busy_off", Busy, 0);
      chk("sat", Sat_Flag, exp_sat);
    end
  endtask

  initial begin
    logic busy_seen;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_outs", outs_all, 0);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | Busy;
    end
    chk("idle_no_start", busy_seen, 0);

    // Basic drain
    for (int k = 0; k < DEPTH; k++) mem[k] = PSW'(k * 16);
    run_drain(6'd4, 0, 0, 0);

    // Saturation and oversized shift
    for (int k = 0; k < DEPTH; k++) mem[k] = PSW'($urandom_range(0, 200));
    mem[3] = 45'h1FFF_FFFF_FFFF;
    run_drain(6'd0, 0, 0, 0);
    run_drain(6'd50, 2, 0, 0);

    // Backpressure on entry 2
    fill_rand();
    run_drain(6'($urandom_range(0, 40)), 1, 0, 0);

    // Rounding boundary values
    fill_rand();
    mem[0] = 45'd23;
    mem[1] = 45'd20;
    mem[2] = 45'd19;
    run_drain(6'd3, 0, 0, 0);

    // Start while busy is ignored
    fill_rand();
    run_drain(6'd7, 0, 1, 0);

    // Reset during HOLD of entry 4, then a fresh drain from entry 0
    fill_rand();
    run_drain(6'd9, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("abort_held", outs_all, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_resume", Busy, 0);
    run_drain(6'd9, 0, 0, 0);

    // Random drains
    repeat (12) begin
      fill_rand();
      run_drain(6'($urandom_range(0, 63)), 2, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
